// File: rtl/soc_interrupt_controller_v2_pkg.sv
// Shared constants and types for the SoC interrupt controller.
package soc_int_pkg;

    localparam int INT_ID_W = 5;
    localparam int MAX_INT  = 32;

    typedef enum logic {
        INT_LEVEL = 1'b0,
        INT_EDGE  = 1'b1
    } int_mode_e;

endpackage

// File: rtl/soc_interrupt_controller_v2_if.sv
// CPU-facing interrupt line: request flag plus the id of the source being offered.
interface SoC_InterruptBus;
    import soc_int_pkg::*;

    logic                irq;
    logic [INT_ID_W-1:0] irq_id;

    modport Generator (output irq, output irq_id);
    modport Receiver  (input  irq, input  irq_id);

endinterface

// File: rtl/soc_interrupt_controller_v2_prio_select.sv
// Highest-priority picker over an eligible vector; ties go to the lowest index.
module soc_int_prio_select
    import soc_int_pkg::*;
#(
    parameter int NUM_INT   = 32,
    parameter int PRIO_BITS = 3
) (
    input  logic [NUM_INT-1:0]           eligible,
    input  logic [NUM_INT*PRIO_BITS-1:0] prio,
    output logic                         valid,
    output logic [INT_ID_W-1:0]          id
);

    localparam int LEAVES = 1 << $clog2(NUM_INT);
    localparam int NODES  = 2 * LEAVES - 1;

    logic                 node_v  [NODES];
    logic [PRIO_BITS-1:0] node_p  [NODES];
    logic [INT_ID_W-1:0]  node_id [NODES];

    // Balanced tree keeps the compare depth at log2(NUM_INT) for 32 sources.
    always_comb begin
        // NOTE: every node gets a value before any branch so no latch can be inferred.
        for (int n = 0; n < NODES; n++) begin
            node_v[n]  = 1'b0;
            node_p[n]  = '0;
            node_id[n] = '0;
        end

        for (int i = 0; i < NUM_INT; i++) begin
            node_v[LEAVES-1+i]  = eligible[i];
            node_p[LEAVES-1+i]  = prio[i*PRIO_BITS +: PRIO_BITS];
            node_id[LEAVES-1+i] = INT_ID_W'(i);
        end

        // The left child always holds the lower indices, so it wins on equal priority.
        for (int n = LEAVES - 2; n >= 0; n--) begin
            if (node_v[2*n+2] && (!node_v[2*n+1] || node_p[2*n+2] > node_p[2*n+1])) begin
                node_v[n]  = 1'b1;
                node_p[n]  = node_p[2*n+2];
                node_id[n] = node_id[2*n+2];
            end else begin
                node_v[n]  = node_v[2*n+1];
                node_p[n]  = node_p[2*n+1];
                node_id[n] = node_id[2*n+1];
            end
        end

        valid = node_v[0];
        id    = node_v[0] ? node_id[0] : '0;
    end

endmodule

// File: rtl/soc_interrupt_controller_v2.sv
// Priority interrupt controller: edge/level sources, pending and in-service tracking,
// threshold masking and nested delivery on a single CPU interrupt line.
module soc_interrupt_controller_v2
    import soc_int_pkg::*;
#(
    parameter int NUM_INT   = 32,
    parameter int PRIO_BITS = 3
) (
    input  logic                         clk,
    input  logic                         res,
    SoC_InterruptBus.Generator           int_bus,
    input  logic [NUM_INT-1:0]           enabled_int,
    input  logic [NUM_INT-1:0]           int_mode,
    input  logic [NUM_INT*PRIO_BITS-1:0] int_prio,
    input  logic [PRIO_BITS-1:0]         prio_threshold,
    input  logic [NUM_INT-1:0]           int_triggers,
    input  logic [NUM_INT-1:0]           int_clears,
    input  logic                         claim,
    input  logic                         complete,
    input  logic [INT_ID_W-1:0]          complete_id,
    output logic [NUM_INT-1:0]           pending,
    output logic [NUM_INT-1:0]           in_service
);

    logic [NUM_INT-1:0]           en_q;
    logic [NUM_INT-1:0]           mode_q;
    logic [NUM_INT*PRIO_BITS-1:0] prio_q;
    logic [PRIO_BITS-1:0]         thr_q;

    logic [NUM_INT-1:0] trig_q;
    logic [NUM_INT-1:0] armed;

    logic [NUM_INT-1:0] eligible;
    logic [NUM_INT-1:0] trig_set;
    logic [NUM_INT-1:0] claim_vec;
    logic [NUM_INT-1:0] complete_vec;
    logic [NUM_INT-1:0] pending_n;
    logic [NUM_INT-1:0] in_service_n;

    logic                sel_valid;
    logic [INT_ID_W-1:0] sel_id;

    // Configuration is captured once per cycle so irq/irq_id depend on flops only
    // and a config change takes effect on the following cycle.
    // NOTE: these are plain data registers; nothing is gated by them while pending is
    // held at zero, so they need no reset.
    always_ff @(posedge clk) begin
        en_q   <= enabled_int;
        mode_q <= int_mode;
        prio_q <= int_prio;
        thr_q  <= prio_threshold;
    end

    // armed marks sources seen low since reset, so a trigger already high when
    // reset is released does not count as an edge.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (res) begin
            pending    <= '0;
            in_service <= '0;
            trig_q     <= '0;
            armed      <= '0;
        end else begin
            pending    <= pending_n;
            in_service <= in_service_n;
            trig_q     <= int_triggers;
            armed      <= armed | ~int_triggers;
        end
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            eligible[i] = pending[i] & en_q[i] & ~in_service[i]
                        & (prio_q[i*PRIO_BITS +: PRIO_BITS] > thr_q);
        end
    end

    soc_int_prio_select #(
        .NUM_INT   (NUM_INT),
        .PRIO_BITS (PRIO_BITS)
    ) u_select (
        .eligible (eligible),
        .prio     (prio_q),
        .valid    (sel_valid),
        .id       (sel_id)
    );

    // Comparing against each in-range index drops complete_id >= NUM_INT for free.
    always_comb begin
        trig_set     = '0;
        claim_vec    = '0;
        complete_vec = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            if (int_mode_e'(mode_q[i]) == INT_EDGE) begin
                trig_set[i] = int_triggers[i] & ~trig_q[i] & armed[i];
            end else begin
                trig_set[i] = int_triggers[i];
            end
            claim_vec[i]    = claim & sel_valid & (sel_id == INT_ID_W'(i));
            complete_vec[i] = complete & (complete_id == INT_ID_W'(i));
        end
        // A new trigger outranks any clear; a claim outranks a same-cycle complete.
        pending_n    = (pending & ~(int_clears | claim_vec)) | trig_set;
        in_service_n = (in_service & ~complete_vec) | claim_vec;
    end

    assign int_bus.irq    = sel_valid;
    assign int_bus.irq_id = sel_id;

endmodule

// File: tb/tb_soc_interrupt_controller_v2.sv
// Directed and randomized bench for soc_interrupt_controller_v2 against a per-source reference model.
module tb_soc_interrupt_controller_v2;
    import soc_int_pkg::*;

    localparam int N  = 12;
    localparam int PB = 3;
    localparam int PW = N * PB;

    logic                clk = 1'b0;
    logic                res;
    logic [N-1:0]        enabled_int;
    logic [N-1:0]        int_mode;
    logic [PW-1:0]       int_prio;
    logic [PB-1:0]       prio_threshold;
    logic [N-1:0]        int_triggers;
    logic [N-1:0]        int_clears;
    logic                claim;
    logic                complete;
    logic [INT_ID_W-1:0] complete_id;
    logic [N-1:0]        pending;
    logic [N-1:0]        in_service;

    SoC_InterruptBus bus ();

    soc_interrupt_controller_v2 #(
        .NUM_INT   (N),
        .PRIO_BITS (PB)
    ) dut (
        .clk            (clk),
        .res            (res),
        .int_bus        (bus),
        .enabled_int    (enabled_int),
        .int_mode       (int_mode),
        .int_prio       (int_prio),
        .prio_threshold (prio_threshold),
        .int_triggers   (int_triggers),
        .int_clears     (int_clears),
        .claim          (claim),
        .complete       (complete),
        .complete_id    (complete_id),
        .pending        (pending),
        .in_service     (in_service)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference model: per-source flags plus the configuration in force this cycle.
    bit m_pend      [N];
    bit m_svc       [N];
    bit m_prev_trig [N];
    bit m_prev_res = 1'b1;
    bit m_en        [N];
    bit m_edge      [N];
    int m_prio      [N];
    int m_thr = 0;

    typedef struct {
        int       cyc;
        bit       irq;
        int       id;
        bit [N-1:0] pend;
        bit [N-1:0] svc;
    } exp_t;

    exp_t sb[$];

    function automatic void pick(output bit v, output int id);
        v  = 1'b0;
        id = 0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_en[i] && !m_svc[i] && m_prio[i] > m_thr
                && (!v || m_prio[i] > m_prio[id])) begin
                v  = 1'b1;
                id = i;
            end
        end
    endfunction

    // Apply the current inputs to the model, queue the post-edge expectation, advance one clock.
    task automatic cycle();
        bit   v;
        int   id;
        exp_t e;
        pick(v, id);
        for (int i = 0; i < N; i++) begin
            bit fire;
            if (res) begin
                m_pend[i] = 1'b0;
                m_svc[i]  = 1'b0;
            end else begin
                fire = m_edge[i] ? (int_triggers[i] && !m_prev_trig[i] && !m_prev_res)
                                 : int_triggers[i];
                if (int_clears[i]) m_pend[i] = 1'b0;
                if (complete && int'(complete_id) == i) m_svc[i] = 1'b0;
                if (claim && v && id == i) begin
                    m_pend[i] = 1'b0;
                    m_svc[i]  = 1'b1;
                end
                if (fire) m_pend[i] = 1'b1;
            end
            m_prev_trig[i] = int_triggers[i];
            m_en[i]        = enabled_int[i];
            m_edge[i]      = int_mode[i];
            m_prio[i]      = int'(int_prio[i*PB +: PB]);
        end
        m_prev_res = res;
        m_thr      = int'(prio_threshold);
        pick(v, id);
        e.cyc = cyc + 1;
        e.irq = v;
        e.id  = id;
        for (int i = 0; i < N; i++) begin
            e.pend[i] = m_pend[i];
            e.svc[i]  = m_svc[i];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                n_total++;
                n_bad++;
                $display("FAIL sb_order: entry for cycle %0d seen at cycle %0d", e.cyc, cyc);
            end
            check("irq",        32'(bus.irq),    32'(e.irq));
            check("irq_id",     32'(bus.irq_id), 32'(e.id));
            check("pending",    32'(pending),    32'(e.pend));
            check("in_service", 32'(in_service), 32'(e.svc));
        end
    end

    task automatic set_prio(input int i, input int p);
        int_prio[i*PB +: PB] = PB'(p);
    endtask

    task automatic strobes_off();
        int_clears  = '0;
        claim       = 1'b0;
        complete    = 1'b0;
        complete_id = '0;
    endtask

    initial begin
        res            = 1'b1;
        enabled_int    = '0;
        int_mode       = '0;
        int_prio       = '0;
        prio_threshold = '0;
        int_triggers   = '0;
        strobes_off();
        repeat (3) cycle();
        check("reset_irq",     32'(bus.irq),    32'd0);
        check("reset_irq_id",  32'(bus.irq_id), 32'd0);
        check("reset_pending", 32'(pending),    32'd0);
        res = 1'b0;

        // Edge source 3 raised and held: one pending set, claim moves it to service.
        enabled_int = '1;
        int_mode    = '0;
        int_mode[3] = 1'b1;
        set_prio(3, 2);
        repeat (2) cycle();
        int_triggers[3] = 1'b1;
        cycle();
        check("a_pending3", 32'(pending[3]),  32'd1);
        check("a_irq",      32'(bus.irq),     32'd1);
        check("a_id",       32'(bus.irq_id),  32'd3);
        repeat (2) cycle();
        claim = 1'b1;
        cycle();
        claim = 1'b0;
        check("a_irq_claimed", 32'(bus.irq),       32'd0);
        check("a_svc3",        32'(in_service[3]), 32'd1);
        check("a_pend3_clr",   32'(pending[3]),    32'd0);
        repeat (3) cycle();
        check("a_held_no_reset", 32'(pending[3]), 32'd0);
        int_triggers[3] = 1'b0;
        complete        = 1'b1;
        complete_id     = 5'd3;
        cycle();
        strobes_off();
        check("a_svc3_done", 32'(in_service[3]), 32'd0);

        // Priority order, ties and threshold on sources 5 and 9.
        int_mode    = '0;
        int_mode[5] = 1'b1;
        int_mode[9] = 1'b1;
        set_prio(5, 1);
        set_prio(9, 3);
        cycle();
        int_triggers[5] = 1'b1;
        int_triggers[9] = 1'b1;
        cycle();
        int_triggers[5] = 1'b0;
        int_triggers[9] = 1'b0;
        check("b_id_hi", 32'(bus.irq_id), 32'd9);
        set_prio(5, 3);
        cycle();
        check("b_id_tie", 32'(bus.irq_id), 32'd5);
        prio_threshold = 3'd3;
        cycle();
        check("b_thr_mask", 32'(bus.irq), 32'd0);
        prio_threshold = 3'd0;
        int_clears[5]  = 1'b1;
        int_clears[9]  = 1'b1;
        cycle();
        strobes_off();

        // Level source 2 held high across claim and complete.
        set_prio(2, 2);
        int_triggers[2] = 1'b1;
        cycle();
        check("c_id", 32'(bus.irq_id), 32'd2);
        claim = 1'b1;
        cycle();
        claim = 1'b0;
        check("c_svc2",  32'(in_service[2]), 32'd1);
        check("c_pend2", 32'(pending[2]),    32'd1);
        check("c_irq0",  32'(bus.irq),       32'd0);
        cycle();
        complete    = 1'b1;
        complete_id = 5'd2;
        cycle();
        strobes_off();
        check("c_irq_again", 32'(bus.irq),    32'd1);
        check("c_id_again",  32'(bus.irq_id), 32'd2);
        int_triggers[2] = 1'b0;
        int_clears[2]   = 1'b1;
        cycle();
        strobes_off();

        // Nesting: 7 in service, 4 (higher) still delivered; out-of-range complete ignored.
        int_mode[7] = 1'b1;
        int_mode[4] = 1'b1;
        set_prio(7, 1);
        set_prio(4, 4);
        cycle();
        int_triggers[7] = 1'b1;
        cycle();
        int_triggers[7] = 1'b0;
        claim = 1'b1;
        cycle();
        claim = 1'b0;
        int_triggers[4] = 1'b1;
        cycle();
        int_triggers[4] = 1'b0;
        check("d_irq", 32'(bus.irq),    32'd1);
        check("d_id",  32'(bus.irq_id), 32'd4);
        complete    = 1'b1;
        complete_id = 5'd31;
        cycle();
        strobes_off();
        check("d_svc_kept", 32'(in_service), 32'h080);
        check("d_id_kept",  32'(bus.irq_id), 32'd4);
        complete      = 1'b1;
        complete_id   = 5'd7;
        int_clears[4] = 1'b1;
        cycle();
        strobes_off();

        // Trigger beats clear; reset mid-service; no edge from a trigger high at reset exit.
        int_mode    = '0;
        int_mode[0] = 1'b1;
        set_prio(0, 5);
        cycle();
        int_triggers[0] = 1'b1;
        int_clears[0]   = 1'b1;
        cycle();
        strobes_off();
        check("e_trig_beats_clr", 32'(pending[0]), 32'd1);
        claim = 1'b1;
        cycle();
        claim = 1'b0;
        check("e_svc0", 32'(in_service[0]), 32'd1);
        res = 1'b1;
        cycle();
        check("e_rst_irq",  32'(bus.irq),    32'd0);
        check("e_rst_id",   32'(bus.irq_id), 32'd0);
        check("e_rst_pend", 32'(pending),    32'd0);
        check("e_rst_svc",  32'(in_service), 32'd0);
        res = 1'b0;
        repeat (3) cycle();
        check("e_no_edge_after_rst", 32'(pending[0]), 32'd0);
        int_triggers[0] = 1'b0;
        cycle();
        int_triggers[0] = 1'b1;
        cycle();
        check("e_rearmed", 32'(pending[0]), 32'd1);
        int_triggers[0] = 1'b0;

        // Randomized traffic checked by the scoreboard.
        for (int c = 0; c < 1500; c++) begin
            res = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) begin
                enabled_int    = N'($urandom | $urandom);
                int_mode       = N'($urandom);
                int_prio       = PW'({$urandom, $urandom});
                prio_threshold = PB'($urandom_range(0, 2));
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) int_triggers[i] = ~int_triggers[i];
            end
            int_clears  = N'($urandom & $urandom & $urandom & $urandom);
            claim       = ($urandom_range(0, 2) == 0);
            complete    = ($urandom_range(0, 2) == 0);
            complete_id = ($urandom_range(0, 9) == 0) ? 5'd31
                                                      : INT_ID_W'($urandom_range(0, N + 3));
            cycle();
        end

        res          = 1'b0;
        int_triggers = '0;
        strobes_off();
        cycle();
        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
